fifo_rd_packer: RTL and testbench

Downstream consumer of the team's synchronous FIFO. Pops WIDTH-bit words from the FIFO read port whenever data is available and packs PACK consecutive words into one wide beat on a valid/ready master output. A flush request emits a partially filled beat with a lane-keep mask. Lets a narrow write-side stream feed a wide datapath without the FIFO changing width.

---
 rtl/fifo_rd_packer.sv | 107 ++++++++++
 tb/tb_fifo_rd_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops narrow FIFO words and packs PACK of them into one wide valid/ready beat
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data_out,
    output logic                   fifo_r_en,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH*PACK-1:0]  m_data,
    output logic [PACK-1:0]        m_keep
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
    localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);
    localparam logic [CW:0]   PEND_MAX = (CW + 1)'(PACK);

    logic [WIDTH*PACK-1:0] acc;
    logic [CW-1:0]         acc_cnt;
    logic                  inflight;
    logic                  flush_pend;
    logic                  run;

    logic                  out_free;
    logic [CW:0]           pending;
    logic [WIDTH*PACK-1:0] full_beat;
    logic [WIDTH*PACK-1:0] part_beat;
    logic [PACK-1:0]       part_keep;

    // Words already held plus the one in flight must leave room for the next pop.
    assign pending   = {1'b0, acc_cnt} + {{CW{1'b0}}, inflight};
    assign fifo_r_en = run && !fifo_empty && !flush_pend && (pending < PEND_MAX);
    assign out_free  = !m_valid || m_ready;

    always_comb begin
        full_beat = acc;
        full_beat[(PACK-1)*WIDTH +: WIDTH] = fifo_data_out;
        part_beat = '0;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) < acc_cnt) begin
                part_beat[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
                part_keep[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            acc_cnt    <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            run        <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= fifo_r_en;

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (inflight && acc_cnt == CNT_LAST) begin
                // Last lane arriving: bypass the accumulator when the output is free.
                if (out_free) begin
                    m_data  <= full_beat;
                    m_keep  <= '1;
                    m_valid <= 1'b1;
                    acc_cnt <= '0;
                end else begin
                    acc[(PACK-1)*WIDTH +: WIDTH] <= fifo_data_out;
                    acc_cnt <= CNT_FULL;
                end
            end else if (inflight) begin
                acc[acc_cnt*WIDTH +: WIDTH] <= fifo_data_out;
                acc_cnt <= acc_cnt + 1'b1;
            end else if (acc_cnt != '0 && out_free && (acc_cnt == CNT_FULL || flush_pend)) begin
                m_data  <= part_beat;
                m_keep  <= part_keep;
                m_valid <= 1'b1;
                acc_cnt <= '0;
            end

            if (flush_pend) begin
                if (!inflight && (acc_cnt == '0 || out_free)) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_r_en && fifo_empty));
    a_keep_contiguous: assert property (@(posedge clk) disable iff (!rst)
        m_valid |-> ((m_keep & (m_keep + 1'b1)) == '0) && m_keep[0]);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed and randomized self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

    localparam int WIDTH = 8;
    localparam int PACK  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  fifo_empty;
    logic [WIDTH-1:0]      fifo_data_out = '0;
    logic                  fifo_r_en;
    logic                  flush = 1'b0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [WIDTH*PACK-1:0] m_data;
    logic [PACK-1:0]       m_keep;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int fifo_cnt = 0;
    logic [WIDTH-1:0] fq[$];
    int pops = 0;
    int pop_err = 0;
    int first_ren = -1;
    int first_valid = -1;
    int stab_err = 0;
    logic hold = 1'b0;
    logic [WIDTH*PACK-1:0] hold_data = '0;
    logic [PACK-1:0] hold_keep = '0;
    logic [WIDTH*PACK-1:0] bdata[$];
    logic [PACK-1:0] bkeep[$];
    int hs_cyc[$];
    logic [WIDTH-1:0] rxq[$];
    logic [WIDTH-1:0] sent[$];

    fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_r_en(fifo_r_en),
        .flush(flush),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_keep(m_keep)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_cnt == 0);

    // Reference synchronous FIFO read port: data appears the cycle after r_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r_en) begin
            pops++;
            if (fifo_cnt == 0) begin
                pop_err++;
            end else begin
                fifo_data_out <= fq.pop_front();
                fifo_cnt <= fifo_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold && (m_valid !== 1'b1 || m_data !== hold_data || m_keep !== hold_keep))
                stab_err++;
            if (fifo_r_en && first_ren < 0) first_ren = cyc;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                bdata.push_back(m_data);
                bkeep.push_back(m_keep);
                hs_cyc.push_back(cyc);
                for (int i = 0; i < PACK; i++)
                    if (m_keep[i]) rxq.push_back(m_data[i*WIDTH +: WIDTH]);
            end
            hold = m_valid && !m_ready;
            hold_data = m_data;
            hold_keep = m_keep;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + WIDTH'(i));
        fifo_cnt <= fifo_cnt + n;
    endtask

    task automatic clear_mon();
        bdata.delete();
        bkeep.delete();
        hs_cyc.delete();
        rxq.delete();
        first_ren = -1;
        first_valid = -1;
        pops = 0;
        stab_err = 0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && bdata.size() < n; i++) tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(2);
        checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL reset_r_en got=%b exp=0", fifo_r_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", m_data); end
        checks++; if (m_keep !== 4'h0) begin failures++; $display("FAIL reset_keep got=%h exp=0", m_keep); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_full_beats();
        logic [31:0] d0, d1;
        logic [3:0] k0, k1;
        clear_mon();
        m_ready = 1'b1;
        push_n(8, 8'h01);
        wait_beats(2, 40);
        tick(3);
        d0 = (bdata.size() > 0) ? bdata[0] : 'x;
        d1 = (bdata.size() > 1) ? bdata[1] : 'x;
        k0 = (bkeep.size() > 0) ? bkeep[0] : 'x;
        k1 = (bkeep.size() > 1) ? bkeep[1] : 'x;
        checks++; if (bdata.size() !== 2) begin failures++; $display("FAIL full_count got=%0d exp=2", bdata.size()); end
        checks++; if (d0 !== 32'h04030201) begin failures++; $display("FAIL full_beat0 got=%h exp=04030201", d0); end
        checks++; if (d1 !== 32'h08070605) begin failures++; $display("FAIL full_beat1 got=%h exp=08070605", d1); end
        checks++; if (k0 !== 4'hF || k1 !== 4'hF) begin failures++; $display("FAIL full_keep got=%h/%h exp=f/f", k0, k1); end
        checks++; if (first_valid - first_ren !== 5) begin failures++; $display("FAIL full_latency got=%0d exp=5", first_valid - first_ren); end
        checks++; if (pops !== 8) begin failures++; $display("FAIL full_pops got=%0d exp=8", pops); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0, d1;
        int gap;
        clear_mon();
        m_ready = 1'b0;
        push_n(8, 8'h11);
        tick(20);
        checks++; if (pops !== 8) begin failures++; $display("FAIL bp_pops got=%0d exp=8", pops); end
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h14131211) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/14131211", m_valid, m_data); end
        checks++; if (dut.acc !== 32'h18171615) begin failures++; $display("FAIL bp_acc got=%h exp=18171615", dut.acc); end
        checks++; if (dut.acc_cnt !== 3'd4) begin failures++; $display("FAIL bp_acc_cnt got=%0d exp=4", dut.acc_cnt); end
        m_ready = 1'b1;
        tick(4);
        d0 = (bdata.size() > 0) ? bdata[0] : 'x;
        d1 = (bdata.size() > 1) ? bdata[1] : 'x;
        gap = (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1;
        checks++; if (d0 !== 32'h14131211 || d1 !== 32'h18171615) begin failures++; $display("FAIL bp_beats got=%h/%h exp=14131211/18171615", d0, d1); end
        checks++; if (gap !== 1) begin failures++; $display("FAIL bp_back_to_back got=%0d exp=1", gap); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    endtask

    task automatic test_flush();
        logic [31:0] d0;
        logic [3:0] k0;
        int fl;
        clear_mon();
        m_ready = 1'b1;
        push_n(3, 8'hA1);
        tick(8);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_prebeat got=%b exp=0", m_valid); end
        flush = 1'b1;
        fl = cyc;
        tick(1);
        flush = 1'b0;
        tick(5);
        d0 = (bdata.size() > 0) ? bdata[0] : 'x;
        k0 = (bkeep.size() > 0) ? bkeep[0] : 'x;
        checks++; if (bdata.size() !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", bdata.size()); end
        checks++; if (d0 !== 32'h00A3A2A1) begin failures++; $display("FAIL flush_data got=%h exp=00a3a2a1", d0); end
        checks++; if (k0 !== 4'h7) begin failures++; $display("FAIL flush_keep got=%h exp=7", k0); end
        checks++; if (first_valid - fl !== 2) begin failures++; $display("FAIL flush_latency got=%0d exp=2", first_valid - fl); end
        clear_mon();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);
        checks++; if (bdata.size() !== 0 || m_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0d beats exp=0", bdata.size()); end
        checks++; if (dut.flush_pend !== 1'b0) begin failures++; $display("FAIL flush_pend_clear got=%b exp=0", dut.flush_pend); end
    endtask

    task automatic test_empty_single();
        clear_mon();
        tick(10);
        checks++; if (pops !== 0 || first_ren !== -1) begin failures++; $display("FAIL empty_no_pop got=%0d exp=0", pops); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", m_valid); end
        push_n(1, 8'h5A);
        tick(6);
        checks++; if (pops !== 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pops); end
        checks++; if (fifo_empty !== 1'b1 || dut.acc_cnt !== 3'd1) begin failures++; $display("FAIL single_state got=%b/%0d exp=1/1", fifo_empty, dut.acc_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d0;
        logic [3:0] k0;
        logic hit;
        hit = 1'b0;
        push_n(3, 8'h21);
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(1);
            if (dut.acc_cnt == 3'd2 && dut.inflight) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rst_setup got=%b exp=1", hit); end
        rst = 1'b0;
        #1;
        checks++; if ({fifo_r_en, m_valid, m_keep} !== 6'b0 || m_data !== 32'h0) begin failures++; $display("FAIL rst_outputs got=%b%b%h/%h exp=0", fifo_r_en, m_valid, m_keep, m_data); end
        checks++; if (dut.acc_cnt !== 3'd0 || dut.inflight !== 1'b0) begin failures++; $display("FAIL rst_state got=%0d/%b exp=0/0", dut.acc_cnt, dut.inflight); end
        fq.delete();
        fifo_cnt <= 0;
        tick(2);
        rst = 1'b1;
        tick(2);
        clear_mon();
        m_ready = 1'b1;
        push_n(4, 8'h31);
        wait_beats(1, 30);
        tick(2);
        d0 = (bdata.size() > 0) ? bdata[0] : 'x;
        k0 = (bkeep.size() > 0) ? bkeep[0] : 'x;
        checks++; if (d0 !== 32'h34333231 || k0 !== 4'hF) begin failures++; $display("FAIL rst_clean_beat got=%h/%h exp=34333231/f", d0, k0); end
    endtask

    task automatic test_random();
        int pushed;
        int mism;
        logic [WIDTH-1:0] w;
        clear_mon();
        sent.delete();
        pop_err = 0;
        pushed = 0;
        while (pushed < 1000) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                w = WIDTH'($urandom);
                sent.push_back(w);
                push_n(1, w);
                pushed++;
            end
            tick(1);
        end
        for (int i = 0; i < 20000 && rxq.size() < 1000; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        m_ready = 1'b1;
        tick(4);
        mism = 0;
        for (int i = 0; i < 1000; i++)
            if (i >= rxq.size() || rxq[i] !== sent[i]) mism++;
        checks++; if (rxq.size() !== 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", rxq.size()); end
        checks++; if (mism !== 0) begin failures++; $display("FAIL rand_order got=%0d exp=0", mism); end
        checks++; if (pop_err !== 0) begin failures++; $display("FAIL rand_pop_empty got=%0d exp=0", pop_err); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL rand_stable got=%0d exp=0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_full_beats();
        test_backpressure();
        test_flush();
        test_empty_single();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
